// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Forwarding and load-use hazard detection for the in-order pipeline.
// A shadow pipeline of destination records (e[1]=EX .. e[DEPTH]=WB) is compared
// against each ID-stage source. The resulting bypass select is registered into EX.
// A load whose data is not yet forwardable stalls ID and injects a bubble into EX.

module hazard_forward_unit #(
   parameter int RA_W       = 5,
   parameter int NUM_SRC    = 2,
   parameter int DEPTH      = 3,
   parameter int LOAD_READY = 3,
   localparam int SEL_W     = $clog2(DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      advance,
   input  logic                      flush,
   input  logic                      id_valid,
   input  logic [NUM_SRC*RA_W-1:0]   id_rs,
   input  logic [NUM_SRC-1:0]        id_rs_used,
   input  logic [RA_W-1:0]           id_rd,
   input  logic                      id_we,
   input  logic                      id_ld,
   output logic                      stall,
   output logic                      ex_valid,
   output logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel,
   output logic [15:0]               stall_count
);

   // Shadow pipeline, index 1 = EX, index DEPTH = WB
   logic            v_reg  [1:DEPTH];
   logic [RA_W-1:0] rd_reg [1:DEPTH];
   logic            we_reg [1:DEPTH];
   logic            ld_reg [1:DEPTH];

   logic                     ex_valid_reg;
   logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel_reg;
   logic [15:0]              stall_count_reg;

   logic [NUM_SRC*SEL_W-1:0] nsel_next;
   logic [NUM_SRC-1:0]       ld_hit;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         logic [RA_W-1:0]  rs;
         logic [SEL_W-1:0] sel;
         logic             hit_ld;

         assign rs = id_rs[gi*RA_W +: RA_W];

         // Scan oldest to youngest so the youngest matching entry has the final say
         always_comb begin
            sel    = '0;
            hit_ld = 1'b0;
            for (int k = DEPTH; k >= 1; k--) begin
               if (v_reg[k] && we_reg[k] && (rd_reg[k] != '0) && (rd_reg[k] == rs)
                   && id_rs_used[gi] && id_valid) begin
                  // The WB entry writes the regfile on the same edge, so read the regfile
                  sel    = (k < DEPTH) ? SEL_W'(k + 1) : '0;
                  hit_ld = ld_reg[k] && ((k + 1) < LOAD_READY);
               end
            end
         end

         assign nsel_next[gi*SEL_W +: SEL_W] = sel;
         assign ld_hit[gi]                   = hit_ld;
      end
   endgenerate

   // A pending flush kills the consumer anyway, so it never needs to wait
   assign stall = id_valid && !flush && (|ld_hit);

   // Control state: entry valids, EX registers and the stall counter
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 1; k <= DEPTH; k++) begin
            v_reg[k] <= 1'b0;
         end
         ex_valid_reg    <= 1'b0;
         ex_fwd_sel_reg  <= '0;
         stall_count_reg <= '0;
      end else if (advance) begin
         for (int k = DEPTH; k >= 2; k--) begin
            v_reg[k] <= v_reg[k-1];
         end
         if (flush || stall) begin
            v_reg[1]       <= 1'b0;
            ex_valid_reg   <= 1'b0;
            ex_fwd_sel_reg <= '0;
         end else begin
            v_reg[1]       <= id_valid;
            ex_valid_reg   <= id_valid;
            ex_fwd_sel_reg <= nsel_next;
         end
         if (stall && (stall_count_reg != 16'hFFFF)) begin
            stall_count_reg <= stall_count_reg + 16'd1;
         end
      end
   end

   // Entry payload needs no reset; it is qualified by the valid bit
   always_ff @(posedge clk) begin
      if (advance) begin
         for (int k = DEPTH; k >= 2; k--) begin
            rd_reg[k] <= rd_reg[k-1];
            we_reg[k] <= we_reg[k-1];
            ld_reg[k] <= ld_reg[k-1];
         end
         rd_reg[1] <= id_rd;
         we_reg[1] <= id_we;
         ld_reg[1] <= id_ld;
      end
   end

   assign ex_valid    = ex_valid_reg;
   assign ex_fwd_sel  = ex_fwd_sel_reg;
   assign stall_count = stall_count_reg;

endmodule
